mc_control_unit: RTL and testbench

Main control state machine of the multi-cycle MIPS datapath. Sequences every instruction through fetch, decode, execute, memory and write-back. Drives the register file's `Write` strobe and write-address select, plus the memory, IR, PC and ALU steering controls. Sits between the instruction register (opcode source) and the datapath muxes and storage elements.

---
 rtl/mips_pkg.sv | 62 ++++++
 rtl/mc_control_decode.sv | 85 ++++++++
 rtl/mc_control_unit.sv | 101 ++++++++++
 tb/tb_mc_control_unit.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the multi-cycle MIPS control path.
// Holds the opcode constants, the control FSM state encoding, the datapath
// steering encodings and the bundled control-word struct that the decode
// map hands back to the control unit.
package mips_pkg;

  localparam int OPCODE_W = 6;

  // Opcodes recognised by the control unit
  localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OPCODE_W-1:0] OP_J     = 6'b000010;

  // ALUOp
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // ALUSrcB
  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMMSH  = 2'b11;

  // PCSrc
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_READ, S_MEM_WB, S_MEM_WRITE,
    S_EXECUTE, S_ALU_WB, S_BRANCH, S_JUMP, S_ADDI_EX, S_ADDI_WB
  } state_t;

  // pc_write and branch are internal; the PC enable is formed from them.
  typedef struct packed {
    logic       pc_write;
    logic       branch;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       instr_done;
    logic       illegal;
  } ctrl_t;

  function automatic logic is_legal(input logic [OPCODE_W-1:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
  endfunction

endpackage

// File: rtl/mc_control_decode.sv
// Combinational state-to-control map for the multi-cycle control unit.
// Ports:
//   i_state     current FSM state
//   i_opcode    IR opcode (only used to flag illegal opcodes in DECODE)
//   i_mem_ready memory access completes this cycle
//   o_ctrl      control word for the current cycle (before reset gating)
module mc_control_decode
  import mips_pkg::*;
(
  input  state_t              i_state,
  input  logic [OPCODE_W-1:0] i_opcode,
  input  logic                i_mem_ready,
  output ctrl_t               o_ctrl
);

  always_comb begin
    o_ctrl = '0;
    case (i_state)
      S_FETCH: begin
        o_ctrl.mem_read  = 1'b1;
        o_ctrl.alu_src_b = SRCB_FOUR;
        o_ctrl.alu_op    = ALUOP_ADD;
        o_ctrl.pc_src    = PCSRC_ALU;
        // IR and PC update only once the instruction word is actually back
        o_ctrl.ir_write  = i_mem_ready;
        o_ctrl.pc_write  = i_mem_ready;
      end
      S_DECODE: begin
        // Speculatively form the branch target into ALUOut
        o_ctrl.alu_src_b  = SRCB_IMMSH;
        o_ctrl.alu_op     = ALUOP_ADD;
        o_ctrl.illegal    = ~is_legal(i_opcode);
        o_ctrl.instr_done = ~is_legal(i_opcode);
      end
      S_MEM_ADDR, S_ADDI_EX: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_IMM;
        o_ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEM_READ: begin
        o_ctrl.mem_read = 1'b1;
        o_ctrl.iord     = 1'b1;
      end
      S_MEM_WB: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.mem_to_reg = 1'b1;
        o_ctrl.instr_done = 1'b1;
      end
      S_MEM_WRITE: begin
        o_ctrl.mem_write  = 1'b1;
        o_ctrl.iord       = 1'b1;
        o_ctrl.instr_done = i_mem_ready;
      end
      S_EXECUTE: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_B;
        o_ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_ALU_WB: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.reg_dst    = 1'b1;
        o_ctrl.instr_done = 1'b1;
      end
      S_BRANCH: begin
        o_ctrl.alu_src_a  = 1'b1;
        o_ctrl.alu_src_b  = SRCB_B;
        o_ctrl.alu_op     = ALUOP_SUB;
        o_ctrl.branch     = 1'b1;
        o_ctrl.pc_src     = PCSRC_ALUOUT;
        o_ctrl.instr_done = 1'b1;
      end
      S_JUMP: begin
        o_ctrl.pc_write   = 1'b1;
        o_ctrl.pc_src     = PCSRC_JUMP;
        o_ctrl.instr_done = 1'b1;
      end
      S_ADDI_WB: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.instr_done = 1'b1;
      end
      default: o_ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mc_control_unit.sv
// Main control FSM of the multi-cycle MIPS datapath.
// Sequences FETCH -> DECODE -> per-class execute/memory/write-back states and
// drives the datapath steering, memory strobes, IR/PC loads and register
// write enable. Outputs are a Moore map of the state (plus Mem_Ready/Zero),
// forced to 0 while RST is high.
// Ports:
//   CLK, RST (sync, active high), Opcode (IR[31:26]), Zero, Mem_Ready
//   PC_En, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, Write,
//   ALUSrcA, ALUSrcB, ALUOp, PCSrc, Instr_Done, Illegal
module mc_control_unit
  import mips_pkg::*;
#(
  parameter int OPCODE_WIDTH = 6
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [OPCODE_WIDTH-1:0] Opcode,
  input  logic                    Zero,
  input  logic                    Mem_Ready,
  output logic                    PC_En,
  output logic                    IorD,
  output logic                    MemRead,
  output logic                    MemWrite,
  output logic                    IRWrite,
  output logic                    RegDst,
  output logic                    MemtoReg,
  output logic                    Write,
  output logic                    ALUSrcA,
  output logic [1:0]              ALUSrcB,
  output logic [1:0]              ALUOp,
  output logic [1:0]              PCSrc,
  output logic                    Instr_Done,
  output logic                    Illegal
);

  state_t              r_state;
  state_t              w_next;
  ctrl_t               w_ctrl;
  ctrl_t               w_out;
  logic [OPCODE_W-1:0] w_op;

  assign w_op = OPCODE_W'(Opcode);

  always_ff @(posedge CLK) begin
    if (RST) r_state <= S_FETCH;
    else     r_state <= w_next;
  end

  // Opcode is only consulted in DECODE and MEM_ADDR; the IR holds it stable
  // from FETCH until the instruction retires.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:     if (Mem_Ready) w_next = S_DECODE;
      S_DECODE: begin
        case (w_op)
          OP_LW, OP_SW: w_next = S_MEM_ADDR;
          OP_RTYPE:     w_next = S_EXECUTE;
          OP_BEQ:       w_next = S_BRANCH;
          OP_ADDI:      w_next = S_ADDI_EX;
          OP_J:         w_next = S_JUMP;
          default:      w_next = S_FETCH;
        endcase
      end
      S_MEM_ADDR:  w_next = (w_op == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:  if (Mem_Ready) w_next = S_MEM_WB;
      S_MEM_WRITE: if (Mem_Ready) w_next = S_FETCH;
      S_EXECUTE:   w_next = S_ALU_WB;
      S_ADDI_EX:   w_next = S_ADDI_WB;
      S_MEM_WB, S_ALU_WB, S_BRANCH, S_JUMP, S_ADDI_WB: w_next = S_FETCH;
      default:     w_next = S_FETCH;
    endcase
  end

  mc_control_decode u_decode (
    .i_state     (r_state),
    .i_opcode    (w_op),
    .i_mem_ready (Mem_Ready),
    .o_ctrl      (w_ctrl)
  );

  // Reset squashes every strobe in the reset cycle so an abandoned
  // instruction cannot commit a write on the reset edge.
  assign w_out = RST ? '0 : w_ctrl;

  assign PC_En      = w_out.pc_write | (w_out.branch & Zero);
  assign IorD       = w_out.iord;
  assign MemRead    = w_out.mem_read;
  assign MemWrite   = w_out.mem_write;
  assign IRWrite    = w_out.ir_write;
  assign RegDst     = w_out.reg_dst;
  assign MemtoReg   = w_out.mem_to_reg;
  assign Write      = w_out.reg_write;
  assign ALUSrcA    = w_out.alu_src_a;
  assign ALUSrcB    = w_out.alu_src_b;
  assign ALUOp      = w_out.alu_op;
  assign PCSrc      = w_out.pc_src;
  assign Instr_Done = w_out.instr_done;
  assign Illegal    = w_out.illegal;

endmodule

// File: tb/tb_mc_control_unit.sv
// Scoreboard bench for mc_control_unit: each instruction pushes its expected
// per-cycle output words (with the inputs to drive in that cycle) into a
// queue; the drain loop drives each entry and compares the DUT outputs.
module tb_mc_control_unit;

  logic       CLK = 1'b0;
  logic       RST;
  logic [5:0] Opcode;
  logic       Zero;
  logic       Mem_Ready;
  logic       PC_En, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, Write;
  logic       ALUSrcA, Instr_Done, Illegal;
  logic [1:0] ALUSrcB, ALUOp, PCSrc;

  always #5 CLK = ~CLK;

  mc_control_unit #(.OPCODE_WIDTH(6)) dut (
    .CLK(CLK), .RST(RST), .Opcode(Opcode), .Zero(Zero), .Mem_Ready(Mem_Ready),
    .PC_En(PC_En), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .RegDst(RegDst), .MemtoReg(MemtoReg), .Write(Write),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSrc(PCSrc),
    .Instr_Done(Instr_Done), .Illegal(Illegal)
  );

  // {PC_En,IorD,MemRead,MemWrite,IRWrite,RegDst,MemtoReg,Write,ALUSrcA,
  //  ALUSrcB,ALUOp,PCSrc,Instr_Done,Illegal}
  logic [16:0] obs;
  assign obs = {PC_En, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, Write,
                ALUSrcA, ALUSrcB, ALUOp, PCSrc, Instr_Done, Illegal};

  typedef struct {
    string       tag;
    logic        rst;
    logic        mr;
    logic        z;
    logic [5:0]  op;
    logic [16:0] exp;
  } ent_t;

  ent_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [16:0] got, input logic [16:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %05h expected %05h", tag, got, exp);
    end
  endtask

  function automatic logic [16:0] mk(
    input logic pcen, iord, mrd, mwr, irw, rdst, m2r, wr, srca,
    input logic [1:0] srcb, aluop, pcsrc,
    input logic done, ill);
    return {pcen, iord, mrd, mwr, irw, rdst, m2r, wr, srca, srcb, aluop, pcsrc, done, ill};
  endfunction

  task automatic push(input string tag, input logic rst, input logic mr,
                      input logic z, input logic [5:0] op, input logic [16:0] exp);
    ent_t e;
    e.tag = tag; e.rst = rst; e.mr = mr; e.z = z; e.op = op; e.exp = exp;
    sb_q.push_back(e);
  endtask

  // Mem_Ready is irrelevant outside FETCH/MEM_READ/MEM_WRITE; randomise it there.
  function automatic logic rmr();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic instr(input string nm, input logic [5:0] op, input logic z,
                       input int fwait, input int mwait);
    for (int i = 0; i < fwait; i++)
      push({nm, ".fetch_w"}, 0, 0, z, op, mk(0,0,1,0,0,0,0,0,0,2'b01,2'b00,2'b00,0,0));
    push({nm, ".fetch"}, 0, 1, z, op, mk(1,0,1,0,1,0,0,0,0,2'b01,2'b00,2'b00,0,0));
    case (op)
      6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010:
        push({nm, ".decode"}, 0, rmr(), z, op, mk(0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,0,0));
      default:
        push({nm, ".decode_ill"}, 0, rmr(), z, op, mk(0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,1,1));
    endcase
    case (op)
      6'b000000: begin
        push({nm, ".exec"}, 0, rmr(), z, op, mk(0,0,0,0,0,0,0,0,1,2'b00,2'b10,2'b00,0,0));
        push({nm, ".alu_wb"}, 0, rmr(), z, op, mk(0,0,0,0,0,1,0,1,0,2'b00,2'b00,2'b00,1,0));
      end
      6'b100011: begin
        push({nm, ".maddr"}, 0, rmr(), z, op, mk(0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0,0));
        for (int i = 0; i < mwait; i++)
          push({nm, ".mread_w"}, 0, 0, z, op, mk(0,1,1,0,0,0,0,0,0,2'b00,2'b00,2'b00,0,0));
        push({nm, ".mread"}, 0, 1, z, op, mk(0,1,1,0,0,0,0,0,0,2'b00,2'b00,2'b00,0,0));
        push({nm, ".mem_wb"}, 0, rmr(), z, op, mk(0,0,0,0,0,0,1,1,0,2'b00,2'b00,2'b00,1,0));
      end
      6'b101011: begin
        push({nm, ".maddr"}, 0, rmr(), z, op, mk(0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0,0));
        for (int i = 0; i < mwait; i++)
          push({nm, ".mwrite_w"}, 0, 0, z, op, mk(0,1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,0,0));
        push({nm, ".mwrite"}, 0, 1, z, op, mk(0,1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,1,0));
      end
      6'b000100:
        push({nm, ".branch"}, 0, rmr(), z, op, mk(z,0,0,0,0,0,0,0,1,2'b00,2'b01,2'b01,1,0));
      6'b000010:
        push({nm, ".jump"}, 0, rmr(), z, op, mk(1,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b10,1,0));
      6'b001000: begin
        push({nm, ".addi_ex"}, 0, rmr(), z, op, mk(0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0,0));
        push({nm, ".addi_wb"}, 0, rmr(), z, op, mk(0,0,0,0,0,0,0,1,0,2'b00,2'b00,2'b00,1,0));
      end
      default: ;
    endcase
  endtask

  // Drive each entry just after the rising edge, compare on the falling edge.
  logic prev_wr = 1'b0;
  task automatic drain();
    ent_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      @(posedge CLK); #1;
      RST = e.rst; Mem_Ready = e.mr; Zero = e.z; Opcode = e.op;
      @(negedge CLK);
      chk(e.tag, obs, e.exp);
      chk("write_1cyc", 17'(Write & prev_wr), 17'd0);
      prev_wr = Write;
    end
  endtask

  initial begin
    RST = 1'b1; Mem_Ready = 1'b0; Zero = 1'b0; Opcode = 6'd0;

    // Reset held for two cycles: everything low, even with Mem_Ready high
    push("rst0", 1, 0, 0, 6'd0, 17'd0);
    push("rst1", 1, 1, 1, 6'd0, 17'd0);
    instr("R",      6'b000000, 0, 0, 0);
    instr("LW_w2",  6'b100011, 0, 0, 2);
    instr("BEQ_z1", 6'b000100, 1, 0, 0);
    instr("BEQ_z0", 6'b000100, 0, 0, 0);
    instr("ILL",    6'b111111, 0, 0, 0);
    instr("J",      6'b000010, 0, 0, 0);
    instr("ADDI",   6'b001000, 1, 0, 0);
    instr("SW_fw1", 6'b101011, 0, 1, 1);
    instr("LW",     6'b100011, 1, 2, 0);
    drain();

    // Reset arriving while SW waits in MEM_WRITE
    push("swr.fetch",  0, 1, 0, 6'b101011, mk(1,0,1,0,1,0,0,0,0,2'b01,2'b00,2'b00,0,0));
    push("swr.decode", 0, 1, 0, 6'b101011, mk(0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,0,0));
    push("swr.maddr",  0, 1, 0, 6'b101011, mk(0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0,0));
    push("swr.mwr_w",  0, 0, 0, 6'b101011, mk(0,1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,0,0));
    push("swr.rst",    1, 0, 0, 6'b101011, 17'd0);
    push("swr.fetch2", 0, 0, 0, 6'b101011, mk(0,0,1,0,0,0,0,0,0,2'b01,2'b00,2'b00,0,0));
    drain();
    instr("R_after", 6'b000000, 0, 0, 0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
